// File: rtl/gps_axi_lite_regs_if.sv
// AXI4-Lite bus bundle for the GPS correlator register block.
// The master modport drives requests; the slave modport is the register block side.
interface gps_axi_lite_regs_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/gps_axi_lite_regs.sv
// AXI4-Lite control/status registers for one GPS tracking channel (NCO words, epoch counter).
// Optional macro GPS_AXI_WSTRB_EN enables per-byte write strobes; default build writes all 32 bits.
module gps_axi_lite_regs #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 5
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  gps_axi_lite_regs_if.slave      s_axi,
  output logic [C_DATA_WIDTH-1:0] ctrl,
  output logic [C_DATA_WIDTH-1:0] carr_freq,
  output logic [C_DATA_WIDTH-1:0] code_freq,
  output logic [C_DATA_WIDTH-1:0] code_phase,
  output logic                    nco_update,
  input  logic                    epoch_pulse
);

  localparam int DW     = C_DATA_WIDTH;
  localparam int STRB_W = C_DATA_WIDTH / 8;
  localparam int SLOT_W = C_ADDR_WIDTH - 2;

  typedef enum logic [SLOT_W-1:0] {
    SLOT_CTRL       = 3'd0,
    SLOT_CARR_FREQ  = 3'd1,
    SLOT_CODE_FREQ  = 3'd2,
    SLOT_CODE_PHASE = 3'd3,
    SLOT_EPOCH_CNT  = 3'd4
  } slot_e;

  logic [SLOT_W-1:0] aw_slot;
  logic [SLOT_W-1:0] ar_slot;
  logic              wr_accept;
  logic              rd_accept;
  logic [DW-1:0]     wr_mask;
  logic              epoch_clear;
  logic [DW-1:0]     epoch_cnt;
  logic [DW-1:0]     rd_word;
  logic              bvalid;
  logic              rvalid;
  logic [DW-1:0]     rdata;

  assign aw_slot = s_axi.AWADDR[C_ADDR_WIDTH-1:2];
  assign ar_slot = s_axi.ARADDR[C_ADDR_WIDTH-1:2];

  // Handshakes are decided combinationally so READY is high only in the accepting cycle;
  // ARESETN gating keeps READY low while reset is held.
  assign wr_accept = ARESETN & s_axi.AWVALID & s_axi.WVALID & ~bvalid;
  assign rd_accept = ARESETN & s_axi.ARVALID & ~rvalid;

  assign s_axi.AWREADY = wr_accept;
  assign s_axi.WREADY  = wr_accept;
  assign s_axi.ARREADY = rd_accept;
  assign s_axi.BVALID  = bvalid;
  assign s_axi.BRESP   = 2'b00;
  assign s_axi.RVALID  = rvalid;
  assign s_axi.RDATA   = rdata;
  assign s_axi.RRESP   = 2'b00;

  always_comb begin
`ifdef GPS_AXI_WSTRB_EN
    wr_mask = '0;
    for (int n = 0; n < STRB_W; n++) begin
      wr_mask[8*n +: 8] = {8{s_axi.WSTRB[n]}};
    end
`else
    wr_mask = '1;
`endif
  end

  // Bit 1 of CTRL only clears the counter when that byte is actually written.
  assign epoch_clear = wr_accept && (aw_slot == SLOT_CTRL) && s_axi.WDATA[1] && wr_mask[1];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [DW-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // NOTE: every sequential block uses non-blocking assignments so all state samples
  // pre-edge values; this is what makes a same-cycle read return the pre-write data.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl       <= '0;
      carr_freq  <= '0;
      code_freq  <= '0;
      code_phase <= '0;
    end else if (wr_accept) begin
      case (aw_slot)
        SLOT_CTRL:       ctrl       <= merge(ctrl,       s_axi.WDATA, wr_mask);
        SLOT_CARR_FREQ:  carr_freq  <= merge(carr_freq,  s_axi.WDATA, wr_mask);
        SLOT_CODE_FREQ:  code_freq  <= merge(code_freq,  s_axi.WDATA, wr_mask);
        SLOT_CODE_PHASE: code_phase <= merge(code_phase, s_axi.WDATA, wr_mask);
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      epoch_cnt <= '0;
    end else if (epoch_clear) begin
      epoch_cnt <= '0;
    end else if (epoch_pulse) begin
      epoch_cnt <= epoch_cnt + 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      nco_update <= 1'b0;
    end else begin
      nco_update <= wr_accept && ((aw_slot == SLOT_CARR_FREQ) ||
                                  (aw_slot == SLOT_CODE_FREQ) ||
                                  (aw_slot == SLOT_CODE_PHASE));
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bvalid <= 1'b0;
    end else if (wr_accept) begin
      bvalid <= 1'b1;
    end else if (s_axi.BREADY) begin
      bvalid <= 1'b0;
    end
  end

  // NOTE: rd_word gets a default before the case so no latch is inferred for unmapped slots.
  always_comb begin
    rd_word = '0;
    case (ar_slot)
      SLOT_CTRL:       rd_word = ctrl;
      SLOT_CARR_FREQ:  rd_word = carr_freq;
      SLOT_CODE_FREQ:  rd_word = code_freq;
      SLOT_CODE_PHASE: rd_word = code_phase;
      SLOT_EPOCH_CNT:  rd_word = epoch_cnt;
      default:         rd_word = '0;
    endcase
  end

  // RDATA is captured at acceptance and held until the master takes it.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (rd_accept) begin
      rvalid <= 1'b1;
      rdata  <= rd_word;
    end else if (s_axi.RREADY) begin
      rvalid <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0],
                       s_axi.WSTRB};

endmodule

// File: tb/tb_gps_axi_lite_regs.sv
// Self-checking bench for gps_axi_lite_regs: directed vector table, hand-written corner
// sequences and a randomized phase against a word-level register model.
module tb_gps_axi_lite_regs;

  logic        ACLK;
  logic        ARESETN;
  logic [31:0] ctrl, carr_freq, code_freq, code_phase;
  logic        nco_update;
  logic        epoch_pulse;

  gps_axi_lite_regs_if bus ();

  gps_axi_lite_regs dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .s_axi       (bus),
    .ctrl        (ctrl),
    .carr_freq   (carr_freq),
    .code_freq   (code_freq),
    .code_phase  (code_phase),
    .nco_update  (nco_update),
    .epoch_pulse (epoch_pulse)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: four RW words plus a free-running epoch counter.
  logic [31:0] m_reg [4];
  logic [31:0] m_epoch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    int slot = int'(a[4:2]);
    if (slot < 4) return m_reg[slot];
    if (slot == 4) return m_epoch;
    return 32'h0;
  endfunction

  function automatic logic model_nco(input logic [4:0] a);
    int slot = int'(a[4:2]);
    return (slot >= 1) && (slot <= 3);
  endfunction

  // Applies one accepted write (and an epoch pulse in the same cycle) to the model.
  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic ep);
    int slot = int'(a[4:2]);
    logic [31:0] mask;
    logic clr;
`ifdef GPS_AXI_WSTRB_EN
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
`else
    mask = 32'hFFFF_FFFF;
`endif
    if (slot < 4) m_reg[slot] = (m_reg[slot] & ~mask) | (d & mask);
    clr = (slot == 0) && d[1] && mask[1];
    if (clr) m_epoch = 32'h0;
    else if (ep) m_epoch = m_epoch + 32'd1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
    m_epoch = 32'h0;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic ep);
    int n = 0;
    @(negedge ACLK);
    bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; epoch_pulse = ep;
    #1;
    while (!(bus.AWREADY && bus.WREADY) && n < 16) begin
      @(negedge ACLK); #1; n++;
    end
    check("wr_accept_in_time", 32'(n < 16), 32'd1);
    @(posedge ACLK);
    model_write(a, d, s, ep);
    #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; epoch_pulse = 1'b0; bus.BREADY = 1'b1;
    @(negedge ACLK);
    check("bvalid", 32'(bus.BVALID), 32'd1);
    check("bresp", 32'(bus.BRESP), 32'd0);
    check("nco_update", 32'(nco_update), 32'(model_nco(a)));
    @(posedge ACLK); #1;
    bus.BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge ACLK);
    bus.ARADDR = a; bus.ARVALID = 1'b1;
    #1;
    while (!bus.ARREADY && n < 16) begin
      @(negedge ACLK); #1; n++;
    end
    check("rd_accept_in_time", 32'(n < 16), 32'd1);
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
    @(negedge ACLK);
    check("rvalid", 32'(bus.RVALID), 32'd1);
    check("rresp", 32'(bus.RRESP), 32'd0);
    d = bus.RDATA;
    @(posedge ACLK); #1;
    bus.RREADY = 1'b0;
  endtask

  task automatic pulse_epoch(input int k);
    if (k > 0) begin
      @(negedge ACLK);
      epoch_pulse = 1'b1;
      repeat (k) @(posedge ACLK);
      #1;
      epoch_pulse = 1'b0;
      m_epoch = m_epoch + 32'(k);
    end
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] rd_exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [4:0]  ra;
    logic [31:0] rdv;
    logic [3:0]  rs;

    vecs[0] = '{5'h00, 32'h0101_FFFF, 32'h0101_FFFF};
    vecs[1] = '{5'h04, 32'hABCD_0001, 32'hABCD_0001};
    vecs[2] = '{5'h08, 32'hDEAD_0011, 32'hDEAD_0011};
    vecs[3] = '{5'h0C, 32'hBEEF_0011, 32'hBEEF_0011};
    vecs[4] = '{5'h10, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{5'h14, 32'h1234_5678, 32'h0000_0000};
    vecs[6] = '{5'h1F, 32'hCAFE_F00D, 32'h0000_0000};
    vecs[7] = '{5'h07, 32'h0000_0055, 32'h0000_0055};

    ARESETN = 1'b0; epoch_pulse = 1'b0;
    bus.AWADDR = '0; bus.AWPROT = '0; bus.WDATA = '0; bus.WSTRB = '0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARPROT = '0; bus.RREADY = 1'b0;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
    model_reset();
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", 32'(bus.AWREADY), 32'd0);
    check("rst_arready", 32'(bus.ARREADY), 32'd0);
    check("rst_bvalid", 32'(bus.BVALID), 32'd0);
    check("rst_rvalid", 32'(bus.RVALID), 32'd0);
    check("rst_rdata", bus.RDATA, 32'd0);
    check("rst_ctrl", ctrl, 32'd0);
    check("rst_nco", 32'(nco_update), 32'd0);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    ARESETN = 1'b1;

    // Directed table: write each entry, read it back.
    for (int i = 0; i < 8; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, 4'hF, 1'b0);
      axi_read(vecs[i].addr, rd);
      check($sformatf("vec%0d_read", i), rd, vecs[i].rd_exp);
    end
    check("ctrl_out", ctrl, m_reg[0]);
    check("carr_out", carr_freq, m_reg[1]);
    check("codef_out", code_freq, m_reg[2]);
    check("codep_out", code_phase, m_reg[3]);

    // Epoch counting, then a CTRL clear coinciding with a pulse.
    pulse_epoch(5);
    axi_read(5'h10, rd);
    check("epoch_5", rd, 32'h5);
    axi_write(5'h00, 32'h2, 4'hF, 1'b1);
    axi_read(5'h10, rd);
    check("epoch_clear_wins", rd, 32'h0);

    // AWVALID ahead of WVALID, then a stalled response with valids still offered.
    @(negedge ACLK);
    bus.AWADDR = 5'h04; bus.WDATA = 32'h1357_9BDF; bus.WSTRB = 4'hF; bus.AWVALID = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("aw_only_awready", 32'(bus.AWREADY), 32'd0);
      check("aw_only_wready", 32'(bus.WREADY), 32'd0);
      @(negedge ACLK);
    end
    bus.WVALID = 1'b1;
    #1;
    check("both_awready", 32'(bus.AWREADY), 32'd1);
    check("both_wready", 32'(bus.WREADY), 32'd1);
    @(posedge ACLK);
    model_write(5'h04, 32'h1357_9BDF, 4'hF, 1'b0);
    #1;
    bus.WDATA = 32'hFFFF_0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge ACLK); #1;
      check("stall_bvalid", 32'(bus.BVALID), 32'd1);
      check("stall_no_accept", 32'(bus.AWREADY), 32'd0);
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.BREADY = 1'b0;
    @(negedge ACLK);
    check("bvalid_released", 32'(bus.BVALID), 32'd0);
    axi_read(5'h04, rd);
    check("single_write_only", rd, 32'h1357_9BDF);

    // Same-cycle read and write to one address returns the old value.
    @(negedge ACLK);
    bus.AWADDR = 5'h0C; bus.WDATA = 32'h0000_0077; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    bus.ARADDR = 5'h0C; bus.ARVALID = 1'b1;
    #1;
    check("rw_awready", 32'(bus.AWREADY), 32'd1);
    check("rw_arready", 32'(bus.ARREADY), 32'd1);
    rdv = m_reg[3];
    @(posedge ACLK);
    model_write(5'h0C, 32'h0000_0077, 4'hF, 1'b0);
    #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    @(negedge ACLK);
    check("rw_old_data", bus.RDATA, rdv);
    check("rw_nco", 32'(nco_update), 32'd1);
    @(posedge ACLK); #1;
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    axi_read(5'h0C, rd);
    check("rw_new_data", rd, 32'h0000_0077);

    // Byte strobes.
    axi_write(5'h04, 32'h1122_3344, 4'hF, 1'b0);
    axi_write(5'h04, 32'hAABB_CCDD, 4'b0101, 1'b0);
    axi_read(5'h04, rd);
`ifdef GPS_AXI_WSTRB_EN
    check("wstrb_merge", rd, 32'h11BB_33DD);
`else
    check("wstrb_ignored", rd, 32'hAABB_CCDD);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          ra = 5'($urandom_range(0, 31));
          rs = 4'($urandom_range(0, 15));
          axi_write(ra, $urandom, rs, 1'b0);
        end
        1: begin
          ra = 5'($urandom_range(0, 31));
          axi_read(ra, rd);
          check($sformatf("rand_read_%0d_a%02h", i, ra), rd, model_read(ra));
        end
        default: pulse_epoch($urandom_range(0, 6));
      endcase
    end
    axi_read(5'h10, rd);
    check("rand_epoch_final", rd, m_epoch);

    // Reset while a write response is pending.
    axi_write(5'h08, 32'h0000_1234, 4'hF, 1'b0);
    @(negedge ACLK);
    bus.AWADDR = 5'h08; bus.WDATA = 32'h0000_1234; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    @(negedge ACLK);
    check("pre_rst_bvalid", 32'(bus.BVALID), 32'd1);
    #2 ARESETN = 1'b0;
    #1;
    check("rst_async_bvalid", 32'(bus.BVALID), 32'd0);
    check("rst_async_codef", code_freq, 32'd0);
    check("rst_async_nco", 32'(nco_update), 32'd0);
    model_reset();
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) begin
      @(negedge ACLK);
      check("no_aborted_resp", 32'(bus.BVALID), 32'd0);
    end
    axi_read(5'h08, rd);
    check("codef_after_rst", rd, 32'd0);
    axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, 1'b0);
    axi_read(5'h14, rd);
    check("reserved_reads_zero", rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gps_axi_lite_regs.md
GPS_AXI_LITE_REGS -- requirements
Module: gps_axi_lite_regs

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 SHALL have parameter C_ADDR_WIDTH, default 5, byte address width (8 word slots).
REQ-003 SHALL have ports: ACLK in 1, sole clock; ARESETN in 1, asynchronous active-low reset.
REQ-004 SHALL have AXI4-Lite write ports: AWADDR in 5, AWPROT in 3 (ignored), AWVALID in 1, AWREADY out 1, WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1, BRESP out 2, BVALID out 1, BREADY in 1.
REQ-005 SHALL have AXI4-Lite read ports: ARADDR in 5, ARPROT in 3 (ignored), ARVALID in 1, ARREADY out 1, RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1.
REQ-006 SHALL have correlator ports: ctrl out 32, carr_freq out 32, code_freq out 32, code_phase out 32, nco_update out 1 (single-cycle load strobe), epoch_pulse in 1 (1 ms code-epoch tick from the correlator).

Function
REQ-007 Register map (word offset): 0x00 CTRL RW, 0x04 CARR_FREQ RW, 0x08 CODE_FREQ RW, 0x0C CODE_PHASE RW, 0x10 EPOCH_CNT RO, 0x14-0x1C reserved, read 0, writes ignored.
REQ-008 ctrl/carr_freq/code_freq/code_phase outputs SHALL equal their registers directly.
REQ-009 Write accepted in a cycle where AWVALID=1, WVALID=1 and BVALID=0; AWREADY and WREADY SHALL both pulse high for exactly that cycle.
REQ-010 Register update SHALL take effect at the accepting edge; BVALID SHALL rise the following cycle, BRESP=00, held until BREADY=1.
REQ-011 AWVALID alone or WVALID alone SHALL not be accepted; READY stays low until both present.
REQ-012 Read accepted when ARVALID=1 and RVALID=0; ARREADY pulses one cycle; RDATA/RVALID SHALL appear next cycle, RRESP=00, held stable until RREADY=1.
REQ-013 Read and write channels SHALL operate independently; a read accepted in the same cycle as a write to the same address SHALL return the pre-write value.
REQ-014 Address decode SHALL use AWADDR[4:2]/ARADDR[4:2]; bits [1:0] ignored; all accesses respond OKAY.
REQ-015 nco_update SHALL pulse high one cycle after an accepted write to CARR_FREQ, CODE_FREQ or CODE_PHASE; otherwise 0.
REQ-016 EPOCH_CNT SHALL increment by 1 per cycle with epoch_pulse=1, wrapping 0xFFFFFFFF -> 0.
REQ-017 An accepted write to CTRL with WDATA[1]=1 SHALL clear EPOCH_CNT to 0 at that edge; clear wins over a simultaneous epoch_pulse; CTRL bit1 stores as written.
REQ-018 Writes to EPOCH_CNT offset SHALL be ignored (still OKAY).

Reset
REQ-019 ARESETN=0 SHALL asynchronously force all registers, EPOCH_CNT, AWREADY, WREADY, BVALID, ARREADY, RVALID, nco_update to 0 and RDATA to 0.
REQ-020 Reset asserted mid-transaction SHALL abort it; no response issued after release for the aborted transaction.
REQ-021 Deassertion SHALL be honoured at the next ACLK edge; first acceptance possible on that edge.

Configuration
REQ-022 Macro GPS_AXI_WSTRB_EN: when defined, each register byte n updates only if WSTRB[n]=1 (CTRL clear requires WSTRB[0]=1).
REQ-023 Without GPS_AXI_WSTRB_EN, WSTRB SHALL be ignored and every accepted write updates all 32 bits.

Verification
REQ-024 After reset, write 0x0101FFFF@0x00, 0xABCD0001@0x04, 0xDEAD0011@0x08, 0xBEEF0011@0x0C, read each back -> identical data, BRESP=RRESP=00, nco_update pulses on last three only.
REQ-025 Pulse epoch_pulse 5 cycles, read 0x10 -> 0x00000005; write CTRL 0x2 concurrent with epoch_pulse -> next read of 0x10 = 0.
REQ-026 Present AWVALID 3 cycles before WVALID -> AWREADY/WREADY both high only in the WVALID cycle; hold BREADY low 4 cycles -> BVALID stays high, no second write accepted.
REQ-027 With GPS_AXI_WSTRB_EN, CARR_FREQ=0x11223344, write 0xAABBCCDD WSTRB=0101 -> read 0x11BB33DD; without macro -> 0xAABBCCDD.
REQ-028 Assert ARESETN low while BVALID=1 and CODE_FREQ=0x1234 -> BVALID=0 immediately, CODE_FREQ reads 0 after release; write 0x14 then read 0x14 -> 0.
